lv_wdg_scan_ctrl: RTL

- Watchdog register-scan scheduler on the LV side.
- Periodically walks a configurable register address window and issues one read per period on the watchdog-scan read port of the register access arbiter.
- Checks each returned data byte against its stored CRC and reports mismatches, ack timeouts and scan-pass completion to the fault/status logic.
- The scan period restarts whenever SPI traffic forwarded to OWT pulses the watchdog-restart strobe.

---
 rtl/lv_wdg_scan_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/lv_wdg_scan_ctrl.sv
// lv_wdg_scan_ctrl
// Watchdog register-scan scheduler for the LV side. Every SCAN_PERIOD cycles
// it issues one read on the arbiter's watchdog-scan port. It walks the address
// window [i_scan_start_addr, i_scan_end_addr] one address per read. Each
// returned byte is checked against its stored CRC-8 (poly 0x07, init 0x00,
// MSB first). Mismatches, ack timeouts and scan-pass completion are reported.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_scan_en               level, enables scanning
//   i_scan_start_addr       first address of the scan window
//   i_scan_end_addr         last address of the scan window (inclusive)
//   i_spi_rst_wdg           pulse, restarts the period timer while waiting
//   i_err_clr               pulse, clears sticky flags, error address and count
//   o_wdg_scan_rac_rd_req   registered read request to the arbiter
//   o_wdg_scan_rac_addr     registered read address
//   i_rac_wdg_scan_ack      read ack, data and crc valid in the same cycle
//   i_rac_wdg_scan_data     read data
//   i_rac_wdg_scan_crc      stored CRC of the read data
//   o_scan_crc_err          sticky CRC mismatch flag
//   o_scan_err_addr         address of the most recent CRC mismatch
//   o_scan_err_cnt          saturating CRC mismatch count
//   o_scan_ack_tmo          sticky ack-timeout flag
//   o_scan_done             one-cycle pulse after the end address completes
module lv_wdg_scan_ctrl #(
  parameter int REG_AW      = 7,
  parameter int REG_DW      = 8,
  parameter int REG_CRC_W   = 8,
  parameter int SCAN_PERIOD = 1000,
  parameter int ACK_TO      = 64,
  parameter int ERR_CNT_W   = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_scan_en,
  input  logic [REG_AW-1:0]    i_scan_start_addr,
  input  logic [REG_AW-1:0]    i_scan_end_addr,
  input  logic                 i_spi_rst_wdg,
  input  logic                 i_err_clr,
  output logic                 o_wdg_scan_rac_rd_req,
  output logic [REG_AW-1:0]    o_wdg_scan_rac_addr,
  input  logic                 i_rac_wdg_scan_ack,
  input  logic [REG_DW-1:0]    i_rac_wdg_scan_data,
  input  logic [REG_CRC_W-1:0] i_rac_wdg_scan_crc,
  output logic                 o_scan_crc_err,
  output logic [REG_AW-1:0]    o_scan_err_addr,
  output logic [ERR_CNT_W-1:0] o_scan_err_cnt,
  output logic                 o_scan_ack_tmo,
  output logic                 o_scan_done
);

  localparam int TIMER_W = $clog2(SCAN_PERIOD);
  localparam int TMO_W   = $clog2(ACK_TO);
  localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(SCAN_PERIOD - 1);
  localparam logic [TMO_W-1:0]     TMO_LAST   = TMO_W'(ACK_TO - 1);
  localparam logic [REG_CRC_W-1:0] CRC_POLY   = REG_CRC_W'(7);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_REQ
  } state_t;

  state_t              state;
  logic [TIMER_W-1:0]  timer;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [REG_AW-1:0]   pointer;

  logic                crc_bad;
  logic                ack_evt;
  logic                tmo_evt;
  logic                at_end;
  logic [REG_AW-1:0]   next_ptr;

  // Bitwise MSB-first CRC over the data bits only, starting from zero.
  function automatic logic [REG_CRC_W-1:0] crc_calc(input logic [REG_DW-1:0] data);
    logic [REG_CRC_W-1:0] crc;
    logic                 fb;
    crc = '0;
    for (int i = REG_DW - 1; i >= 0; i--) begin
      fb  = crc[REG_CRC_W-1] ^ data[i];
      crc = {crc[REG_CRC_W-2:0], 1'b0};
      if (fb) crc = crc ^ CRC_POLY;
    end
    return crc;
  endfunction

  // Ack/timeout only count while actually requesting and still enabled;
  // a disable in the same cycle discards them. Ack beats a same-cycle timeout.
  always_comb begin
    crc_bad  = (crc_calc(i_rac_wdg_scan_data) != i_rac_wdg_scan_crc);
    ack_evt  = (state == ST_REQ) && i_scan_en && i_rac_wdg_scan_ack;
    tmo_evt  = (state == ST_REQ) && i_scan_en && !i_rac_wdg_scan_ack &&
               (tmo_cnt == TMO_LAST);
    // ">=" also covers a window shrunk below the current pointer and start>end.
    at_end   = (pointer >= i_scan_end_addr);
    next_ptr = at_end ? i_scan_start_addr : pointer + REG_AW'(1);
  end

  // Scan sequencer: idle, count out the period, then hold the request until
  // ack or timeout. Dropping i_scan_en returns to idle from any state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state                 <= ST_IDLE;
      timer                 <= '0;
      tmo_cnt               <= '0;
      pointer               <= '0;
      o_wdg_scan_rac_rd_req <= 1'b0;
      o_wdg_scan_rac_addr   <= '0;
      o_scan_done           <= 1'b0;
    end else begin
      o_scan_done <= 1'b0;
      if (!i_scan_en) begin
        state                 <= ST_IDLE;
        timer                 <= '0;
        tmo_cnt               <= '0;
        o_wdg_scan_rac_rd_req <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            pointer <= i_scan_start_addr;
            timer   <= '0;
            state   <= ST_WAIT;
          end
          ST_WAIT: begin
            // A restart strobe wins over a same-cycle period expiry.
            if (i_spi_rst_wdg) begin
              timer <= '0;
            end else if (timer == TIMER_LAST) begin
              state                 <= ST_REQ;
              timer                 <= '0;
              tmo_cnt               <= '0;
              o_wdg_scan_rac_rd_req <= 1'b1;
              o_wdg_scan_rac_addr   <= pointer;
            end else begin
              timer <= timer + TIMER_W'(1);
            end
          end
          ST_REQ: begin
            if (ack_evt || tmo_evt) begin
              state                 <= ST_WAIT;
              timer                 <= '0;
              o_wdg_scan_rac_rd_req <= 1'b0;
              pointer               <= next_ptr;
              o_scan_done           <= at_end;
            end else begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Sticky error reporting. A clear is applied first so that a new event in
  // the same cycle still lands (flag set, count restarts at one).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_scan_crc_err  <= 1'b0;
      o_scan_err_addr <= '0;
      o_scan_err_cnt  <= '0;
      o_scan_ack_tmo  <= 1'b0;
    end else begin
      if (i_err_clr) begin
        o_scan_crc_err  <= 1'b0;
        o_scan_err_addr <= '0;
        o_scan_err_cnt  <= '0;
        o_scan_ack_tmo  <= 1'b0;
      end
      if (ack_evt && crc_bad) begin
        o_scan_crc_err  <= 1'b1;
        o_scan_err_addr <= pointer;
        if (i_err_clr)
          o_scan_err_cnt <= ERR_CNT_W'(1);
        else if (!(&o_scan_err_cnt))
          o_scan_err_cnt <= o_scan_err_cnt + ERR_CNT_W'(1);
      end
      if (tmo_evt) o_scan_ack_tmo <= 1'b1;
    end
  end

endmodule
